// File: rtl/hog_scale_sched_if.sv
// hog_scale_sched_if: bundles the sequencer's table-programming, configuration,
// software-control and pipeline-handshake signals.
// master = software / HOG pipeline side; slave = the sequencer itself.
interface hog_scale_sched_if #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 32
);
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_addr;
  logic [31:0]       tbl_scale_x;
  logic [31:0]       tbl_scale_y;
  logic [IDX_W:0]    cfg_num;
  logic [ADDR_W-1:0] cfg_out_base;
  logic [ADDR_W-1:0] cfg_out_stride;
  logic              sw_start;
  logic              sw_abort;
  logic              write_feature_done;
  logic              hog_start;
  logic [31:0]       scale_x;
  logic [31:0]       scale_y;
  logic [ADDR_W-1:0] out_addr;
  logic [IDX_W-1:0]  scale_idx;
  logic              busy;
  logic              seq_done;
  logic [1:0]        seq_err;

  modport master (
    output tbl_we, tbl_addr, tbl_scale_x, tbl_scale_y,
    output cfg_num, cfg_out_base, cfg_out_stride,
    output sw_start, sw_abort, write_feature_done,
    input  hog_start, scale_x, scale_y, out_addr, scale_idx,
    input  busy, seq_done, seq_err
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_scale_x, tbl_scale_y,
    input  cfg_num, cfg_out_base, cfg_out_stride,
    input  sw_start, sw_abort, write_feature_done,
    output hog_start, scale_x, scale_y, out_addr, scale_idx,
    output busy, seq_done, seq_err
  );
endinterface

// File: rtl/hog_scale_sched.sv
// hog_scale_sched: multi-scale sequencer in front of the HOG pipeline.
// Walks a programmable table of scale factors, firing one hog_start per entry
// and waiting for write_feature_done before moving to the next entry.
// Optional WAIT-state watchdog: define HOG_SCHED_WDT_EN (parameter WDT_W).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a start request; table writable
// LOAD  | register scale_x/scale_y from table[scale_idx]
// FIRE  | issue the hog_start pulse (registered, visible next cycle)
// WAIT  | hold outputs until write_feature_done
// NEXT  | finish the sequence or advance index / address
// DONE  | pulse seq_done, drop busy
//
// sw_start and the cfg_* values are captured into shadow registers on the
// cycle the request is seen; IDLE validates the captured request one cycle
// later. All outputs are registered, which sets the 3-cycle start/done to
// hog_start latency and the 2-cycle last-done to seq_done latency.
module hog_scale_sched #(
  parameter int N_SCALES = 8,
  parameter int IDX_W    = 3,
  parameter int ADDR_W   = 32
`ifdef HOG_SCHED_WDT_EN
  , parameter int WDT_W  = 24
`endif
) (
  input logic              aclk,
  input logic              arest_n,
  hog_scale_sched_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(N_SCALES);

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [IDX_W:0]    num_q, num_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sx_q, sx_d;
  logic [31:0]       sy_q, sy_d;
  logic              busy_q, busy_d;
  logic              hog_start_q, hog_start_d;
  logic              seq_done_q, seq_done_d;
  logic [1:0]        err_q, err_d;
  logic [63:0]       tbl_q [N_SCALES];
  logic [63:0]       tbl_d [N_SCALES];
  logic              num_ok;
  logic              last_scale;

`ifdef HOG_SCHED_WDT_EN
  // one below terminal count: the compare fires as the counter reaches all-ones
  localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};
  logic [WDT_W-1:0] wdt_q, wdt_d;
`endif

  assign num_ok     = (bus.cfg_num != '0) && (bus.cfg_num <= NUM_MAX);
  assign last_scale = ({1'b0, idx_q} == (num_q - (IDX_W+1)'(1)));

  // Table write path: software may only reprogram while no sequence is running
  always_comb begin
    tbl_d = tbl_q;
    if (bus.tbl_we && !busy_q) begin
      tbl_d[bus.tbl_addr] = {bus.tbl_scale_y, bus.tbl_scale_x};
    end
  end

  // Next-state and output computation for the sequencing FSM
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    num_d       = num_q;
    base_d      = base_q;
    stride_d    = stride_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    busy_d      = busy_q;
    err_d       = err_q;
    hog_start_d = 1'b0;
    seq_done_d  = 1'b0;
`ifdef HOG_SCHED_WDT_EN
    wdt_d       = wdt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          start_d = 1'b0;
          if ((num_q != '0) && (num_q <= NUM_MAX)) begin
            idx_d   = '0;
            addr_d  = base_q;
            err_d   = 2'd0;
            busy_d  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            err_d = 2'd1;
          end
        end else if (bus.sw_start) begin
          start_d  = 1'b1;
          num_d    = bus.cfg_num;
          base_d   = bus.cfg_out_base;
          stride_d = bus.cfg_out_stride;
        end
      end
      ST_LOAD: begin
        sx_d    = tbl_q[idx_q][31:0];
        sy_d    = tbl_q[idx_q][63:32];
        state_d = ST_FIRE;
      end
      ST_FIRE: begin
        hog_start_d = 1'b1;
        state_d     = ST_WAIT;
`ifdef HOG_SCHED_WDT_EN
        wdt_d       = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.write_feature_done) begin
          state_d = ST_NEXT;
        end
`ifdef HOG_SCHED_WDT_EN
        else if (wdt_q == WDT_LAST) begin
          wdt_d   = wdt_q + WDT_W'(1);
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 2'd3;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
`endif
      end
      ST_NEXT: begin
        if (last_scale) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          addr_d  = addr_q + stride_q;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        seq_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // abort wins over everything else, including a pending pulse or done
    if (bus.sw_abort && busy_q) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      err_d       = 2'd2;
      hog_start_d = 1'b0;
      seq_done_d  = 1'b0;
    end
  end

  // FSM and output registers
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      num_q       <= '0;
      base_q      <= '0;
      stride_q    <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      busy_q      <= 1'b0;
      hog_start_q <= 1'b0;
      seq_done_q  <= 1'b0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      num_q       <= num_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      busy_q      <= busy_d;
      hog_start_q <= hog_start_d;
      seq_done_q  <= seq_done_d;
      err_q       <= err_d;
    end
  end

  // Scale table storage, cleared by reset
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      for (int i = 0; i < N_SCALES; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SCALES; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

`ifdef HOG_SCHED_WDT_EN
  // WAIT-state watchdog counter
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`endif

  assign bus.hog_start = hog_start_q;
  assign bus.scale_x   = sx_q;
  assign bus.scale_y   = sy_q;
  assign bus.out_addr  = addr_q;
  assign bus.scale_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.seq_err   = err_q;

endmodule

// File: tb/tb_hog_scale_sched.sv
// tb_hog_scale_sched: randomized self-checking bench for hog_scale_sched.
// A reference model (table copy plus latency/address arithmetic) predicts each
// hog_start event and the seq_done pulse of every run.
module tb_hog_scale_sched;

`ifdef HOG_SCHED_WDT_EN
  localparam int DLY_CAP = 10;
`else
  localparam int DLY_CAP = 60;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] sx;
    logic [31:0] sy;
    logic [31:0] addr;
    int          idx;
  } hog_ev_t;

  logic        aclk = 1'b0;
  logic        arest_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] model_tbl [8];
  hog_ev_t     hog_q [$];
  int          done_q [$];

  hog_scale_sched_if #(.IDX_W(3), .ADDR_W(32)) bif ();

  hog_scale_sched #(
    .N_SCALES(8), .IDX_W(3), .ADDR_W(32)
`ifdef HOG_SCHED_WDT_EN
    , .WDT_W(4)
`endif
  ) dut (
    .aclk    (aclk),
    .arest_n (arest_n),
    .bus     (bif)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // record every hog_start and seq_done pulse with the edge it followed
  always @(negedge aclk) begin
    hog_ev_t ev;
    if (bif.hog_start === 1'b1) begin
      ev.cyc  = cyc;
      ev.sx   = bif.scale_x;
      ev.sy   = bif.scale_y;
      ev.addr = bif.out_addr;
      ev.idx  = int'(bif.scale_idx);
      hog_q.push_back(ev);
    end
    if (bif.seq_done === 1'b1) done_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=cyc%0d exp=finish", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, "_hog_start"}, bif.hog_start, 0);
    chk({ph, "_busy"},      bif.busy, 0);
    chk({ph, "_seq_done"},  bif.seq_done, 0);
    chk({ph, "_seq_err"},   bif.seq_err, 0);
    chk({ph, "_scale_x"},   bif.scale_x, 0);
    chk({ph, "_scale_y"},   bif.scale_y, 0);
    chk({ph, "_out_addr"},  bif.out_addr, 0);
    chk({ph, "_scale_idx"}, bif.scale_idx, 0);
  endtask

  task automatic tbl_write(input int idx, input logic [31:0] x, input logic [31:0] y);
    bif.tbl_we      = 1'b1;
    bif.tbl_addr    = 3'(idx);
    bif.tbl_scale_x = x;
    bif.tbl_scale_y = y;
    step();
    bif.tbl_we = 1'b0;
    model_tbl[idx] = {y, x};
  endtask

  task automatic pulse_start(input int num);
    bif.cfg_num  = 4'(num);
    bif.sw_start = 1'b1;
    step();
    bif.sw_start = 1'b0;
  endtask

  // mode 0: full run; 1: abort together with done at scale stop_at;
  // 2: async reset in WAIT of scale stop_at
  task automatic run_seq(input int num, input logic [31:0] base, input logic [31:0] stride,
                         input int fix_dly, input int mode, input int stop_at);
    int          n0, d0, prev_edge, dly, budget;
    hog_ev_t     ev;
    logic [31:0] exp_addr;
    n0 = hog_q.size();
    d0 = done_q.size();
    bif.cfg_num        = 4'(num);
    bif.cfg_out_base   = base;
    bif.cfg_out_stride = stride;
    bif.sw_start       = 1'b1;
    prev_edge          = cyc + 1;
    step();
    bif.sw_start       = 1'b0;
    bif.cfg_num        = 4'($urandom);
    bif.cfg_out_base   = $urandom;
    bif.cfg_out_stride = $urandom;
    for (int i = 0; i < num; i++) begin
      budget = 0;
      while (hog_q.size() <= n0 + i && budget < 100) begin
        step();
        budget++;
      end
      if (hog_q.size() <= n0 + i) begin
        chk("hog_timeout", hog_q.size(), n0 + i + 1);
        return;
      end
      ev = hog_q[n0 + i];
      exp_addr = base + stride * 32'(i);
      chk("hog_latency", ev.cyc, prev_edge + 3);
      chk("scale_x", ev.sx, model_tbl[i][31:0]);
      chk("scale_y", ev.sy, model_tbl[i][63:32]);
      chk("out_addr", ev.addr, exp_addr);
      chk("scale_idx", ev.idx, i);
      chk("busy_run", bif.busy, 1);
      if (mode == 2 && i == stop_at) begin
        repeat (3) step();
        #2 arest_n = 1'b0;
        #1 chk_zero("async_rst");
        for (int k = 0; k < 8; k++) model_tbl[k] = '0;
        @(negedge aclk);
        arest_n = 1'b1;
        #1;
        return;
      end
      dly = (fix_dly > 0) ? ((fix_dly > DLY_CAP) ? DLY_CAP : fix_dly) : $urandom_range(1, DLY_CAP);
      for (int k = 0; k < dly; k++) begin
        bif.tbl_we      = ($urandom_range(0, 3) == 0);
        bif.tbl_addr    = 3'($urandom);
        bif.tbl_scale_x = $urandom;
        bif.tbl_scale_y = $urandom;
        bif.sw_start    = ($urandom_range(0, 4) == 0);
        step();
      end
      bif.tbl_we   = 1'b0;
      bif.sw_start = 1'b0;
      bif.write_feature_done = 1'b1;
      if (mode == 1 && i == stop_at) bif.sw_abort = 1'b1;
      prev_edge = cyc + 1;
      step();
      bif.write_feature_done = 1'b0;
      bif.sw_abort = 1'b0;
      if (mode == 1 && i == stop_at) begin
        chk("abort_busy", bif.busy, 0);
        chk("abort_err", bif.seq_err, 2);
        repeat (20) step();
        chk("abort_hogs", hog_q.size(), n0 + i + 1);
        chk("abort_no_done", done_q.size(), d0);
        return;
      end
    end
    repeat (4) step();
    chk("done_count", done_q.size(), d0 + 1);
    if (done_q.size() > d0) chk("done_latency", done_q[d0], prev_edge + 2);
    chk("hog_count", hog_q.size(), n0 + num);
    chk("busy_after", bif.busy, 0);
    chk("err_after", bif.seq_err, 0);
  endtask

  initial begin
    int n0, num;
    int c0, budget, d0;
    logic [31:0] rx, ry;
    bif.tbl_we = 1'b0;
    bif.tbl_addr = '0;
    bif.tbl_scale_x = '0;
    bif.tbl_scale_y = '0;
    bif.cfg_num = '0;
    bif.cfg_out_base = '0;
    bif.cfg_out_stride = '0;
    bif.sw_start = 1'b0;
    bif.sw_abort = 1'b0;
    bif.write_feature_done = 1'b0;
    for (int k = 0; k < 8; k++) model_tbl[k] = '0;

    repeat (3) step();
    chk_zero("reset");
    @(negedge aclk);
    arest_n = 1'b1;
    #1;

    // directed 3-scale run
    tbl_write(0, 32'h400, 32'h400);
    tbl_write(1, 32'h500, 32'h500);
    tbl_write(2, 32'h600, 32'h600);
    run_seq(3, 32'h1000_0000, 32'h2000, 50, 0, 0);

    // bad cfg_num values
    n0 = hog_q.size();
    pulse_start(0);
    repeat (4) step();
    chk("bad0_err", bif.seq_err, 1);
    chk("bad0_busy", bif.busy, 0);
    pulse_start(9);
    repeat (4) step();
    chk("bad9_err", bif.seq_err, 1);
    chk("bad9_busy", bif.busy, 0);
    chk("bad_no_hog", hog_q.size(), n0);

    // abort and stray done in IDLE have no effect
    bif.sw_abort = 1'b1;
    step();
    bif.sw_abort = 1'b0;
    bif.write_feature_done = 1'b1;
    step();
    bif.write_feature_done = 1'b0;
    repeat (5) step();
    chk("idle_abort_err", bif.seq_err, 1);
    chk("idle_done_busy", bif.busy, 0);
    chk("idle_done_hog", hog_q.size(), n0);

    // abort coincident with done during scale 1 of 4
    tbl_write(3, 32'h700, 32'h780);
    run_seq(4, 32'h2000_0000, 32'h100, 0, 1, 1);

    // randomized runs with stray table writes / starts while busy
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) begin
        rx = $urandom;
        ry = $urandom;
        tbl_write(k, rx, ry);
      end
      num = $urandom_range(1, 8);
      run_seq(num, $urandom, $urandom, 0, 0, 0);
    end

    // address wrap, then async reset while waiting on the second scale
    tbl_write(0, 32'hAAAA_0001, 32'h5555_0002);
    tbl_write(1, 32'hAAAA_0003, 32'h5555_0004);
    run_seq(2, 32'hFFFF_F000, 32'h2000, 5, 2, 1);
    step();
    chk_zero("post_rst");
    run_seq(1, 32'h0000_0040, 32'h10, 3, 0, 0);

`ifdef HOG_SCHED_WDT_EN
    tbl_write(0, 32'h123, 32'h456);
    n0 = hog_q.size();
    d0 = done_q.size();
    pulse_start(1);
    budget = 0;
    while (hog_q.size() <= n0 && budget < 50) begin
      step();
      budget++;
    end
    chk("wdt_hog_seen", hog_q.size(), n0 + 1);
    c0 = cyc;
    budget = 0;
    while (bif.busy === 1'b1 && budget < 60) begin
      step();
      budget++;
    end
    chk("wdt_cycles", cyc - c0, 15);
    chk("wdt_err", bif.seq_err, 3);
    chk("wdt_no_done", done_q.size(), d0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
